// File: rtl/hpdcache_victim_evict.sv
// Purpose : eviction controller between the HPDcache victim selector and the refill/writeback paths.
// Latency : request -> selector strobe 1 cycle; clean grant at +2; dirty writeback request at +4.
// Backpr. : wb_ready_i / alloc_ready_i low stall indefinitely with payload held; one request in flight.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   req_*                        refill request (valid/ready, set index)
//   sel_*                        victim selector strobe/set out, one-hot way + directory bits back
//   tag_rd_*                     tag array read (data returns the cycle after the strobe)
//   wb_*                         writeback request handshake, payload and completion pulse
//   alloc_*                      freed-way grant handshake to the refill engine
//   evict_cnt_o, wb_cnt_o        saturating statistics (HPDCACHE_VICTIM_EVICT_STATS_EN), else 0
// Optional feature macro: HPDCACHE_VICTIM_EVICT_STATS_EN enables the statistics counters.
module hpdcache_victim_evict #(
  parameter int unsigned WAYS      = 4,
  parameter int unsigned SET_WIDTH = 7,
  parameter int unsigned TAG_WIDTH = 20,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [SET_WIDTH-1:0] req_set_i,
  output logic                 sel_victim_o,
  output logic [SET_WIDTH-1:0] sel_victim_set_o,
  input  logic [WAYS-1:0]      sel_victim_way_i,
  input  logic [WAYS-1:0]      sel_dir_valid_i,
  input  logic [WAYS-1:0]      sel_dir_dirty_i,
  output logic                 tag_rd_o,
  output logic [SET_WIDTH-1:0] tag_rd_set_o,
  output logic [WAYS-1:0]      tag_rd_way_o,
  input  logic [TAG_WIDTH-1:0] tag_rd_data_i,
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic [SET_WIDTH-1:0] wb_set_o,
  output logic [WAYS-1:0]      wb_way_o,
  output logic [TAG_WIDTH-1:0] wb_tag_o,
  input  logic                 wb_done_i,
  output logic                 alloc_valid_o,
  input  logic                 alloc_ready_i,
  output logic [SET_WIDTH-1:0] alloc_set_o,
  output logic [WAYS-1:0]      alloc_way_o,
  output logic [CNT_WIDTH-1:0] evict_cnt_o,
  output logic [CNT_WIDTH-1:0] wb_cnt_o
);

  typedef enum logic [2:0] {
    IDLE, SEL, TAG, TAGW, WB_REQ, WB_WAIT, GRANT
  } state_t;

  state_t                 state;
  logic [SET_WIDTH-1:0]   set_q;
  logic [WAYS-1:0]        way_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic                   req_ready_q;
  logic                   sel_victim_q;
  logic                   tag_rd_q;
  logic                   wb_valid_q;
  logic                   alloc_valid_q;

  // Victim needs a writeback only if the chosen way holds a valid dirty line.
  logic victim_dirty;
  logic victim_found;
  assign victim_dirty = |(sel_victim_way_i & sel_dir_valid_i & sel_dir_dirty_i);
  assign victim_found = |sel_victim_way_i;

  // Strobes/valids are flops updated together with the state, so they never
  // depend combinationally on an input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      set_q         <= '0;
      way_q         <= '0;
      tag_q         <= '0;
      req_ready_q   <= 1'b1;
      sel_victim_q  <= 1'b0;
      tag_rd_q      <= 1'b0;
      wb_valid_q    <= 1'b0;
      alloc_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            set_q        <= req_set_i;
            req_ready_q  <= 1'b0;
            sel_victim_q <= 1'b1;
            state        <= SEL;
          end
        end
        SEL: begin
          way_q <= sel_victim_way_i;
          // An all-zero reply means every way is busy fetching: strobe again.
          if (victim_found) begin
            sel_victim_q <= 1'b0;
            if (victim_dirty) begin
              tag_rd_q <= 1'b1;
              state    <= TAG;
            end else begin
              alloc_valid_q <= 1'b1;
              state         <= GRANT;
            end
          end
        end
        TAG: begin
          tag_rd_q <= 1'b0;
          state    <= TAGW;
        end
        TAGW: begin
          tag_q      <= tag_rd_data_i;
          wb_valid_q <= 1'b1;
          state      <= WB_REQ;
        end
        WB_REQ: begin
          if (wb_ready_i) begin
            wb_valid_q <= 1'b0;
            state      <= WB_WAIT;
          end
        end
        WB_WAIT: begin
          if (wb_done_i) begin
            alloc_valid_q <= 1'b1;
            state         <= GRANT;
          end
        end
        GRANT: begin
          if (alloc_ready_i) begin
            alloc_valid_q <= 1'b0;
            req_ready_q   <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          req_ready_q   <= 1'b1;
          sel_victim_q  <= 1'b0;
          tag_rd_q      <= 1'b0;
          wb_valid_q    <= 1'b0;
          alloc_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o      = req_ready_q;
  assign sel_victim_o     = sel_victim_q;
  assign sel_victim_set_o = set_q;
  assign tag_rd_o         = tag_rd_q;
  assign tag_rd_set_o     = set_q;
  assign tag_rd_way_o     = way_q;
  assign wb_valid_o       = wb_valid_q;
  assign wb_set_o         = set_q;
  assign wb_way_o         = way_q;
  assign wb_tag_o         = tag_q;
  assign alloc_valid_o    = alloc_valid_q;
  assign alloc_set_o      = set_q;
  assign alloc_way_o      = way_q;

`ifdef HPDCACHE_VICTIM_EVICT_STATS_EN
  logic [CNT_WIDTH-1:0] evict_cnt_q;
  logic [CNT_WIDTH-1:0] wb_cnt_q;

  // Saturating counters: stop at all-ones rather than wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      evict_cnt_q <= '0;
      wb_cnt_q    <= '0;
    end else begin
      if (alloc_valid_q && alloc_ready_i && (evict_cnt_q != {CNT_WIDTH{1'b1}})) begin
        evict_cnt_q <= evict_cnt_q + 1'b1;
      end
      if (wb_valid_q && wb_ready_i && (wb_cnt_q != {CNT_WIDTH{1'b1}})) begin
        wb_cnt_q <= wb_cnt_q + 1'b1;
      end
    end
  end

  assign evict_cnt_o = evict_cnt_q;
  assign wb_cnt_o    = wb_cnt_q;
`else
  assign evict_cnt_o = '0;
  assign wb_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_hpdcache_victim_evict.sv
// Directed bench for hpdcache_victim_evict: clean/dirty/busy-selector flows,
// writeback and grant backpressure, reset mid-writeback and statistics counters.
module tb_hpdcache_victim_evict;

  localparam int WAYS = 4;
  localparam int SW   = 7;
  localparam int TW   = 20;
  localparam int CW   = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [SW-1:0] req_set_i;
  logic          sel_victim_o;
  logic [SW-1:0] sel_victim_set_o;
  logic [WAYS-1:0] sel_victim_way_i;
  logic [WAYS-1:0] sel_dir_valid_i;
  logic [WAYS-1:0] sel_dir_dirty_i;
  logic          tag_rd_o;
  logic [SW-1:0] tag_rd_set_o;
  logic [WAYS-1:0] tag_rd_way_o;
  logic [TW-1:0] tag_rd_data_i;
  logic          wb_valid_o;
  logic          wb_ready_i;
  logic [SW-1:0] wb_set_o;
  logic [WAYS-1:0] wb_way_o;
  logic [TW-1:0] wb_tag_o;
  logic          wb_done_i;
  logic          alloc_valid_o;
  logic          alloc_ready_i;
  logic [SW-1:0] alloc_set_o;
  logic [WAYS-1:0] alloc_way_o;
  logic [CW-1:0] evict_cnt_o;
  logic [CW-1:0] wb_cnt_o;

  int n_assert = 0;
  int n_fail   = 0;
  int wb_hs    = 0;
  int alloc_hs = 0;
  int tag_rds  = 0;
  int wb_hs0;
  int alloc_hs0;
  int tag_rds0;

`ifdef HPDCACHE_VICTIM_EVICT_STATS_EN
  localparam int STAT_ONE = 1;
  localparam int STAT_SAT = 3;
`else
  localparam int STAT_ONE = 0;
  localparam int STAT_SAT = 0;
`endif

  hpdcache_victim_evict #(
    .WAYS(WAYS), .SET_WIDTH(SW), .TAG_WIDTH(TW), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_set_i(req_set_i),
    .sel_victim_o(sel_victim_o), .sel_victim_set_o(sel_victim_set_o),
    .sel_victim_way_i(sel_victim_way_i), .sel_dir_valid_i(sel_dir_valid_i),
    .sel_dir_dirty_i(sel_dir_dirty_i),
    .tag_rd_o(tag_rd_o), .tag_rd_set_o(tag_rd_set_o), .tag_rd_way_o(tag_rd_way_o),
    .tag_rd_data_i(tag_rd_data_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_set_o(wb_set_o),
    .wb_way_o(wb_way_o), .wb_tag_o(wb_tag_o), .wb_done_i(wb_done_i),
    .alloc_valid_o(alloc_valid_o), .alloc_ready_i(alloc_ready_i),
    .alloc_set_o(alloc_set_o), .alloc_way_o(alloc_way_o),
    .evict_cnt_o(evict_cnt_o), .wb_cnt_o(wb_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Handshake / strobe event counters, sampled at the active edge.
  always @(posedge clk_i) begin
    if (wb_valid_o && wb_ready_i)       wb_hs    <= wb_hs + 1;
    if (alloc_valid_o && alloc_ready_i) alloc_hs <= alloc_hs + 1;
    if (tag_rd_o)                       tag_rds  <= tag_rds + 1;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Unchecked dirty eviction with immediate writeback ready/done and grant ready.
  task automatic dirty_evict(input logic [SW-1:0] s, input logic [WAYS-1:0] w, input logic [TW-1:0] t);
    req_set_i = s; sel_victim_way_i = w; sel_dir_valid_i = w; sel_dir_dirty_i = w;
    req_valid_i = 1'b1; step();          // c1 SEL
    req_valid_i = 1'b0; step();          // c2 TAG
    step();                              // c3 TAGW
    tag_rd_data_i = t; step();           // c4 WB_REQ
    wb_ready_i = 1'b1; step();           // c5 WB_WAIT
    wb_ready_i = 1'b0; wb_done_i = 1'b1; step();  // c6 GRANT
    wb_done_i = 1'b0; alloc_ready_i = 1'b1; step(); // c7 IDLE
    alloc_ready_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_set_i = '0;
    sel_victim_way_i = '0; sel_dir_valid_i = '0; sel_dir_dirty_i = '0;
    tag_rd_data_i = '0; wb_ready_i = 1'b0; wb_done_i = 1'b0; alloc_ready_i = 1'b0;
    step(); step();

    // ---- reset state
    chk("rst_sel", sel_victim_o, 0);
    chk("rst_tag_rd", tag_rd_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_alloc_valid", alloc_valid_o, 0);
    chk("rst_wb_tag", wb_tag_o, 0);
    chk("rst_alloc_way", alloc_way_o, 0);
    rst_i = 1'b0; step();
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_evict_cnt", evict_cnt_o, 0);
    chk("rst_wb_cnt", wb_cnt_o, 0);

    // ---- invalid victim way: straight to grant, no tag read, no writeback
    tag_rds0 = tag_rds; wb_hs0 = wb_hs;
    req_set_i = 7'd3; sel_victim_way_i = 4'b0001; sel_dir_valid_i = 4'b0000; sel_dir_dirty_i = 4'b0000;
    req_valid_i = 1'b1; step();          // c1
    req_valid_i = 1'b0;
    chk("inv_sel_c1", sel_victim_o, 1);
    chk("inv_sel_set", sel_victim_set_o, 3);
    chk("inv_req_ready_c1", req_ready_o, 0);
    step();                              // c2
    chk("inv_alloc_valid_c2", alloc_valid_o, 1);
    chk("inv_alloc_way", alloc_way_o, 4'b0001);
    chk("inv_alloc_set", alloc_set_o, 3);
    chk("inv_sel_c2", sel_victim_o, 0);
    alloc_ready_i = 1'b1; step();        // c3
    alloc_ready_i = 1'b0;
    chk("inv_alloc_drop", alloc_valid_o, 0);
    chk("inv_req_ready_c3", req_ready_o, 1);
    chk("inv_no_tag_rd", tag_rds - tag_rds0, 0);
    chk("inv_no_wb", wb_hs - wb_hs0, 0);

    // ---- dirty victim, done 10 cycles after writeback handshake
    req_set_i = 7'd5; sel_victim_way_i = 4'b0100; sel_dir_valid_i = 4'b0100; sel_dir_dirty_i = 4'b0100;
    req_valid_i = 1'b1; step();          // c1
    req_valid_i = 1'b0;
    chk("dty_sel_c1", sel_victim_o, 1);
    step();                              // c2
    chk("dty_tag_rd_c2", tag_rd_o, 1);
    chk("dty_tag_rd_set", tag_rd_set_o, 5);
    chk("dty_tag_rd_way", tag_rd_way_o, 4'b0100);
    chk("dty_alloc_c2", alloc_valid_o, 0);
    step();                              // c3
    tag_rd_data_i = 20'hABCDE;
    chk("dty_tag_rd_c3", tag_rd_o, 0);
    chk("dty_wb_valid_c3", wb_valid_o, 0);
    step();                              // c4
    tag_rd_data_i = 20'h0;
    chk("dty_wb_valid_c4", wb_valid_o, 1);
    chk("dty_wb_set", wb_set_o, 5);
    chk("dty_wb_way", wb_way_o, 4'b0100);
    chk("dty_wb_tag", wb_tag_o, 20'hABCDE);
    wb_ready_i = 1'b1; step();           // c5
    wb_ready_i = 1'b0;
    chk("dty_wb_valid_c5", wb_valid_o, 0);
    repeat (9) step();                   // c14
    chk("dty_alloc_before_done", alloc_valid_o, 0);
    chk("dty_wb_tag_held", wb_tag_o, 20'hABCDE);
    wb_done_i = 1'b1; step();            // c15
    wb_done_i = 1'b0;
    chk("dty_alloc_after_done", alloc_valid_o, 1);
    chk("dty_alloc_way", alloc_way_o, 4'b0100);
    chk("dty_alloc_set", alloc_set_o, 5);
    alloc_ready_i = 1'b1; step();
    alloc_ready_i = 1'b0;
    chk("dty_req_ready", req_ready_o, 1);

    // ---- selector busy for 3 cycles, then way 1 (clean)
    req_set_i = 7'd9; sel_victim_way_i = 4'b0000; sel_dir_valid_i = 4'b1111; sel_dir_dirty_i = 4'b0000;
    req_valid_i = 1'b1; step();          // c1
    req_valid_i = 1'b0;
    chk("busy_sel_c1", sel_victim_o, 1);
    step(); chk("busy_sel_c2", sel_victim_o, 1);
    step(); chk("busy_sel_c3", sel_victim_o, 1);
    step();                              // c4
    chk("busy_sel_c4", sel_victim_o, 1);
    chk("busy_alloc_c4", alloc_valid_o, 0);
    sel_victim_way_i = 4'b0010;
    step();                              // c5
    chk("busy_sel_c5", sel_victim_o, 0);
    chk("busy_alloc_c5", alloc_valid_o, 1);
    chk("busy_alloc_way", alloc_way_o, 4'b0010);
    alloc_ready_i = 1'b1; step();
    alloc_ready_i = 1'b0;

    // ---- backpressure on writeback and grant
    wb_hs0 = wb_hs; alloc_hs0 = alloc_hs;
    req_set_i = 7'd7; sel_victim_way_i = 4'b1000; sel_dir_valid_i = 4'b1000; sel_dir_dirty_i = 4'b1000;
    req_valid_i = 1'b1; step();          // c1
    req_valid_i = 1'b0; step();          // c2
    step();                              // c3
    tag_rd_data_i = 20'h12345; step();   // c4: WB_REQ, ready held low
    tag_rd_data_i = 20'h0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_wb_valid", wb_valid_o, 1);
      chk("bp_wb_set", wb_set_o, 7);
      chk("bp_wb_way", wb_way_o, 4'b1000);
      chk("bp_wb_tag", wb_tag_o, 20'h12345);
      step();
    end
    chk("bp_wb_no_hs_yet", wb_hs - wb_hs0, 0);
    wb_ready_i = 1'b1; step();
    wb_ready_i = 1'b0;
    chk("bp_wb_valid_drop", wb_valid_o, 0);
    wb_done_i = 1'b1; step();
    wb_done_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_alloc_valid", alloc_valid_o, 1);
      chk("bp_alloc_set", alloc_set_o, 7);
      chk("bp_alloc_way", alloc_way_o, 4'b1000);
      step();
    end
    chk("bp_alloc_no_hs_yet", alloc_hs - alloc_hs0, 0);
    alloc_ready_i = 1'b1; step();
    alloc_ready_i = 1'b0;
    chk("bp_alloc_drop", alloc_valid_o, 0);
    repeat (3) step();
    chk("bp_wb_one_hs", wb_hs - wb_hs0, 1);
    chk("bp_alloc_one_hs", alloc_hs - alloc_hs0, 1);

    // ---- reset during WB_WAIT, then a stray completion pulse
    alloc_hs0 = alloc_hs;
    req_set_i = 7'd11; sel_victim_way_i = 4'b0001; sel_dir_valid_i = 4'b0001; sel_dir_dirty_i = 4'b0001;
    req_valid_i = 1'b1; step();
    req_valid_i = 1'b0; step(); step();
    tag_rd_data_i = 20'hFEDCB; step();   // c4 WB_REQ
    wb_ready_i = 1'b1; step();           // c5 WB_WAIT
    wb_ready_i = 1'b0; step();
    rst_i = 1'b1; #1;
    chk("mid_rst_wb_valid", wb_valid_o, 0);
    chk("mid_rst_alloc_valid", alloc_valid_o, 0);
    chk("mid_rst_wb_tag", wb_tag_o, 0);
    chk("mid_rst_wb_set", wb_set_o, 0);
    chk("mid_rst_alloc_way", alloc_way_o, 0);
    chk("mid_rst_req_ready", req_ready_o, 1);
    step();
    rst_i = 1'b0; step();
    wb_done_i = 1'b1; step();
    wb_done_i = 1'b0; step();
    chk("stray_done_alloc", alloc_valid_o, 0);
    chk("stray_done_req_ready", req_ready_o, 1);
    chk("stray_done_no_hs", alloc_hs - alloc_hs0, 0);
    chk("mid_rst_evict_cnt", evict_cnt_o, 0);

    // ---- statistics: 5 dirty evictions with 2-bit counters
    dirty_evict(7'd1, 4'b0010, 20'h00001);
    chk("stat_evict_one", evict_cnt_o, STAT_ONE);
    chk("stat_wb_one", wb_cnt_o, STAT_ONE);
    for (int i = 0; i < 4; i++) begin
      dirty_evict(7'd2, 4'b0100, 20'h00002);
    end
    chk("stat_evict_sat", evict_cnt_o, STAT_SAT);
    chk("stat_wb_sat", wb_cnt_o, STAT_SAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
